spi_slave_responder: RTL

// - Synthesizable SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, single lane).
// - Answers the pulpino_top SPI master port (spi_master_clk_o/csn0_o/sdo0_o/sdi0_i).
// - Received bytes go into an RX FIFO. Response bytes are taken from a TX FIFO.
// - Used as an on-board responder / FPGA peripheral stand-in for the behavioural SPI slave model.

---
 rtl/spi_slave_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) with RX and TX byte FIFOs.
// All SPI pins are synchronized into clk; SCK edges are detected on the
// synchronized copy, so SCK must run at clk/8 or slower.
module spi_slave_responder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck_i,
  input  logic       spi_csn_i,
  input  logic       spi_sdi_i,
  output logic       spi_sdo_o,
  output logic       spi_sdo_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       underrun_o,
  output logic       overflow_o,
  input  logic       flag_clr_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic        sdo_oe_q, sdo_oe_d;
  logic        underrun_q, underrun_d;
  logic        overflow_q, overflow_d;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic       sck_rise, sck_fall, csn_high, csn_low_stable, sdi_s;
  logic       load, rx_push, rx_accept, rx_pop, tx_push, tx_pop;
  logic       tx_full, tx_empty, rx_full, underrun_set, overflow_set;
  logic [7:0] rx_byte, tx_head;

  // Shift each SPI input through its synchronizer chain (bit 0 is the newest)
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
    csn_sync_d = {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_i};
  end

  // SCK edges and CSN level share the same stage so a final fall and a CSN
  // rise launched together are seen in the same cycle (CSN then wins).
  // A transfer only starts once two consecutive CSN samples are low.
  assign sck_rise       = sck_sync_q[SYNC_STAGES-2] & ~sck_sync_q[SYNC_STAGES-1];
  assign sck_fall       = ~sck_sync_q[SYNC_STAGES-2] & sck_sync_q[SYNC_STAGES-1];
  assign csn_high       = csn_sync_q[SYNC_STAGES-2];
  assign csn_low_stable = ~csn_sync_q[SYNC_STAGES-2] & ~csn_sync_q[SYNC_STAGES-1];
  assign sdi_s          = sdi_sync_q[SYNC_STAGES-1];
  assign rx_byte        = {rx_shift_q, sdi_s};

  // FIFO status and handshakes
  assign tx_full    = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty   = (tx_cnt_q == '0);
  assign rx_full    = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_ready_o = ~tx_full;
  assign tx_push    = tx_valid_i & ~tx_full;
  assign tx_head    = tx_mem[tx_rd_ptr_q];
  assign rx_valid_o = (rx_cnt_q != '0);
  assign rx_data_o  = rx_valid_o ? rx_mem[rx_rd_ptr_q] : 8'h00;
  assign rx_pop     = rx_valid_o & rx_ready_i;

  // A full RX FIFO still accepts a byte if its head is popped the same cycle
  assign rx_accept    = rx_push & (~rx_full | rx_pop);
  assign overflow_set = rx_push & ~rx_accept;
  assign tx_pop       = load & ~tx_empty;
  assign underrun_set = load & tx_empty;

  // FSM next-state: byte framing, shift registers and TX reloads
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    sdo_oe_d   = sdo_oe_q;
    load       = 1'b0;
    rx_push    = 1'b0;
    case (state_q)
      IDLE: begin
        sdo_oe_d  = 1'b0;
        bit_cnt_d = 3'd0;
        if (csn_low_stable) begin
          load     = 1'b1;
          sdo_oe_d = 1'b1;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (csn_high) begin
          // Partial RX byte is abandoned; the popped TX byte is not returned
          state_d   = IDLE;
          sdo_oe_d  = 1'b0;
          bit_cnt_d = 3'd0;
        end else if (sck_rise) begin
          rx_shift_d = rx_byte[6:0];
          bit_cnt_d  = bit_cnt_q + 3'd1;
          rx_push    = (bit_cnt_q == 3'd7);
        end else if (sck_fall) begin
          if (bit_cnt_q != 3'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      tx_shift_d = tx_empty ? 8'h00 : tx_head;
    end
  end

  // FIFO pointers, fill counts and sticky flags (a set beats a clear)
  always_comb begin
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + AW'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop ? tx_rd_ptr_q + AW'(1) : tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wr_ptr_d = rx_accept ? rx_wr_ptr_q + AW'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop ? rx_rd_ptr_q + AW'(1) : rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q + CW'(rx_accept) - CW'(rx_pop);
    underrun_d  = (underrun_q & ~flag_clr_i) | underrun_set;
    overflow_d  = (overflow_q & ~flag_clr_i) | overflow_set;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      csn_sync_q  <= '1;
      sdi_sync_q  <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 7'h00;
      sdo_oe_q    <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      csn_sync_q  <= csn_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      sdo_oe_q    <= sdo_oe_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

  // FIFO storage writes (storage itself needs no reset; counts gate it)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_data_i;
    if (rx_accept) rx_mem[rx_wr_ptr_q] <= rx_byte;
  end

  assign spi_sdo_oe_o = sdo_oe_q;
  assign spi_sdo_o    = sdo_oe_q & tx_shift_q[7];
  assign underrun_o   = underrun_q;
  assign overflow_o   = overflow_q;

endmodule
